// File: rtl/mcu_command_decoder_if.sv
// Handshake bundle between the UART receive side, the decoder and the
// transceiver configuration logic that consumes decoded commands.
interface mcu_command_decoder_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                      cmd_enable;
  logic [DATA_WIDTH-1:0]     rx_data;
  logic                      rx_valid;
  logic                      cmd_valid;
  logic [2:0]                cmd_type;
  logic [5*DATA_WIDTH-1:0]   cfg_data;
  logic                      cmd_ack;
  logic                      cmd_error;
  logic                      busy;

  // Byte source and command consumer side
  modport master (
    output cmd_enable, rx_data, rx_valid, cmd_ack,
    input  cmd_valid, cmd_type, cfg_data, cmd_error, busy
  );

  // Decoder side
  modport slave (
    input  cmd_enable, rx_data, rx_valid, cmd_ack,
    output cmd_valid, cmd_type, cfg_data, cmd_error, busy
  );
endinterface

// File: rtl/mcu_command_decoder.sv
// E32-style command decoder: parses C0/C2 + 5 parameter bytes and C1/C3/C4
// triples from the UART byte stream while in sleep/config mode, and holds one
// decoded command on a valid/ack handshake. Bad bytes and stalls pulse error.
module mcu_command_decoder #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 960
) (
  input logic                  clk,
  input logic                  rst,
  mcu_command_decoder_if.slave bus
);

  localparam int unsigned CfgW = 5 * DATA_WIDTH;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES - 1);

  localparam logic [DATA_WIDTH-1:0] HdWrSave = DATA_WIDTH'(8'hC0);
  localparam logic [DATA_WIDTH-1:0] HdRdCfg  = DATA_WIDTH'(8'hC1);
  localparam logic [DATA_WIDTH-1:0] HdWrTemp = DATA_WIDTH'(8'hC2);
  localparam logic [DATA_WIDTH-1:0] HdRdVer  = DATA_WIDTH'(8'hC3);
  localparam logic [DATA_WIDTH-1:0] HdReset  = DATA_WIDTH'(8'hC4);

  typedef enum logic [1:0] {StIdle, StCollect, StRepeat, StPending} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [2:0]            idx_q, idx_d;
  logic [1:0]            rep_q, rep_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic [CfgW-1:0]       cfg_q, cfg_d;
  logic [2:0]            type_q, type_d;
  logic                  err_q, err_d;
  logic                  valid_q;
  logic                  busy_q;
  logic [2:0]            head_type;

  // Map the stored head byte to its command code
  always_comb begin
    head_type = 3'd0;
    unique case (head_q)
      HdWrSave: head_type = 3'd1;
      HdRdCfg:  head_type = 3'd2;
      HdWrTemp: head_type = 3'd3;
      HdRdVer:  head_type = 3'd4;
      HdReset:  head_type = 3'd5;
      default:  head_type = 3'd0;
    endcase
  end

  // Next-state, counter and output decode
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    tmo_d   = tmo_q;
    cfg_d   = cfg_q;
    type_d  = type_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_enable && bus.rx_valid) begin
          if (bus.rx_data == HdWrSave || bus.rx_data == HdWrTemp) begin
            head_d  = bus.rx_data;
            idx_d   = 3'd0;
            tmo_d   = '0;
            state_d = StCollect;
          end else if (bus.rx_data == HdRdCfg || bus.rx_data == HdRdVer ||
                       bus.rx_data == HdReset) begin
            head_d  = bus.rx_data;
            rep_d   = 2'd1;
            tmo_d   = '0;
            state_d = StRepeat;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StCollect: begin
        // Abort wins over both a byte and a timeout in the same cycle
        if (!bus.cmd_enable) begin
          state_d = StIdle;
        end else if (bus.rx_valid) begin
          for (int i = 0; i < 5; i++) begin
            if (idx_q == 3'(i)) begin
              cfg_d[CfgW - DATA_WIDTH * (i + 1) +: DATA_WIDTH] = bus.rx_data;
            end
          end
          idx_d = idx_q + 3'd1;
          tmo_d = '0;
          if (idx_q == 3'd4) begin
            state_d = StPending;
            type_d  = head_type;
          end
        end else if (tmo_q == TmoMax) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StRepeat: begin
        if (!bus.cmd_enable) begin
          state_d = StIdle;
        end else if (bus.rx_valid) begin
          if (bus.rx_data == head_q) begin
            rep_d = rep_q + 2'd1;
            tmo_d = '0;
            if (rep_q == 2'd2) begin
              state_d = StPending;
              type_d  = head_type;
            end
          end else begin
            // Mismatching byte is consumed, not re-parsed as a new head
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end else if (tmo_q == TmoMax) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StPending: begin
        if (bus.cmd_ack) begin
          state_d = StIdle;
          type_d  = 3'd0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; valid/busy track the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      head_q  <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      tmo_q   <= '0;
      cfg_q   <= '0;
      type_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      tmo_q   <= tmo_d;
      cfg_q   <= cfg_d;
      type_q  <= type_d;
      err_q   <= err_d;
      valid_q <= (state_d == StPending);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign bus.cmd_valid = valid_q;
  assign bus.cmd_type  = type_q;
  assign bus.cfg_data  = cfg_q;
  assign bus.cmd_error = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/mcu_command_decoder.md
# mcu_command_decoder

Byte-stream command decoder between the MCU-side `com_uart` receive port (`data_bus_out`/`RX_flag`) and the `RF_transceiver` configuration/control logic. While the transceiver is in sleep/config mode (M0=M1=1) it parses E32-style commands and presents one decoded command at a time on a valid/ack handshake:

- C0/C2 + 5 parameter bytes: write config, save / temporary.
- C1×3: read config.
- C3×3: read version.
- C4×3: reset.

Malformed sequences and inter-byte timeouts raise a one-cycle error pulse.

## Interface
Parameters:
- `DATA_WIDTH`, 8, UART byte width; fixed at 8 for E32 command bytes.
- `TIMEOUT_CYCLES`, 960, maximum idle `clk` cycles between bytes of one command. Minimum 2. Counter width is `$clog2(TIMEOUT_CYCLES)`.

Ports:
- `clk` in 1: internal (prescaled) clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_enable` in 1: high when `mode_controller` = 3 (sleep/config mode).
- `rx_data` in 8: received byte. Sampled only when `rx_valid`=1.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `cmd_valid` out 1: decoded command available. Held until acknowledged.
- `cmd_type` out 3:
  - 0 none
  - 1 WRITE_SAVE (C0)
  - 2 READ_CFG (C1)
  - 3 WRITE_TEMP (C2)
  - 4 READ_VER (C3)
  - 5 RESET (C4)
- `cfg_data` out 40: {ADDH, ADDL, SPED, CHAN, OPTION}; first parameter byte in [39:32].
- `cmd_ack` in 1: consumer accepts the command.
- `cmd_error` out 1: one-cycle pulse on a malformed sequence or timeout.
- `busy` out 1: high in any state other than IDLE.

## Operation
States are IDLE, COLLECT, REPEAT and PENDING. Internal registers:
- `head`: 8 bits.
- `idx`: 3 bits.
- `rep_cnt`: 2 bits.
- `tmo_cnt`: timeout counter.

IDLE:
- `cmd_enable`=0: `rx_valid` bytes are ignored silently; no error.
- C0 or C2: store `head`, set `idx`=0, clear `tmo_cnt`, go to COLLECT.
- C1, C3 or C4: store `head`, set `rep_cnt`=1, clear `tmo_cnt`, go to REPEAT.
- Any other byte: pulse `cmd_error`, stay in IDLE.

COLLECT:
- Each byte is written to the `cfg_data` slot `idx`, then `idx`++ and `tmo_cnt` is cleared.
- On the 5th byte (`idx`=4): go to PENDING, with `cmd_type` = 1 (C0) or 3 (C2).
- Any byte value is legal here, including C0–C4.

REPEAT:
- Byte equal to `head`: `rep_cnt`++ and `tmo_cnt` is cleared.
- When `rep_cnt` reaches 3: go to PENDING, with `cmd_type` 2, 4 or 5 per `head`.
- Byte not equal to `head`: pulse `cmd_error` and go to IDLE. The offending byte is dropped and not re-parsed as a new head.

Timeout (COLLECT and REPEAT only):
- `tmo_cnt` increments on every cycle without `rx_valid`.
- When `tmo_cnt` = `TIMEOUT_CYCLES`-1 and `rx_valid`=0: pulse `cmd_error` and go to IDLE.
- If `rx_valid` arrives in that same cycle, the byte is accepted and there is no error.

Abort:
- `cmd_enable`=0 while in COLLECT or REPEAT: go to IDLE with no error. Partial `cfg_data` is left as-is but is never validated.

PENDING:
- `cmd_valid`=1; `cmd_type` and `cfg_data` are stable.
- All `rx_valid` bytes are dropped. `cmd_enable` is ignored.
- `cmd_ack`=1: go to IDLE.
- `cmd_ack` while `cmd_valid`=0 has no effect.

In the IDLE → COLLECT transition, `cfg_data` is not cleared. It is fully overwritten before it is ever validated.

## Timing
- Reset values (immediate, asynchronous):
  - state IDLE
  - `cmd_valid`=0, `cmd_type`=0, `cfg_data`=0, `cmd_error`=0, `busy`=0
  - all counters 0
- All outputs are registered.
- Latency, final byte → command: `cmd_valid` rises on the first edge after the final byte's `rx_valid` cycle.
- Latency, ack → release: `cmd_valid`, `busy` and `cmd_type` fall on the edge after `cmd_ack`. `cmd_type` returns to 0.
- A new head byte can be accepted on the cycle following the return to IDLE.
- `cmd_error` is high for exactly one cycle, on the edge after the offending byte or the timeout condition.
- `busy` follows state with the same registered timing: high from the edge after the head byte until the edge after ack, error or abort.
- Back-to-back `rx_valid` on consecutive cycles must be handled; no bytes may be lost outside PENDING.
- Reset asserted mid-command: all progress is discarded and there is no error pulse.

## Test plan
- C0 CD AB 3D 17 C4, one byte every 100 cycles, then `cmd_ack` 5 cycles after `cmd_valid` → `cmd_type`=1, `cfg_data`=40'hCDAB3D17C4, `cmd_valid` held until ack then low, `busy` low one cycle after ack.
- C1 C1 C1 → `cmd_type`=2. C4 C4 C4 → `cmd_type`=5. C3 C3 C3 sent on consecutive cycles → `cmd_type`=4 with no byte lost.
- C4 C4 C1 → `cmd_error` pulse on the cycle after the third byte, no `cmd_valid`, state IDLE. Then C1 C1 C1 → `cmd_type`=2.
- C0 CD, then 960 idle cycles → single `cmd_error` pulse, IDLE. Repeat with the third byte arriving exactly on cycle 959 → no error, collection continues.
- `cmd_enable`=0 while sending C4 C4 C4 → no output, no error. Drop `cmd_enable` after C0 CD → IDLE, no error. Byte 55 in IDLE with enable=1 → `cmd_error`.
- In PENDING, send C1 ×3 before ack → ignored; after ack, `cmd_type`=0. Assert `rst` mid-COLLECT → all outputs 0 immediately.
